// File: rtl/lock_sequencer.sv
// Keypad lock controller: collects 8-bit attempts, replays them into sequence_detector,
// and handles unlock, failure counting, lockout and reprogramming. Define LOCK_ALARM_EN for the lockout alarm pulse.
module lock_sequencer #(
    parameter int         CODE_LEN    = 8,
    parameter int         MAX_TRIES   = 3,
    parameter int         MATCH_WAIT  = 4,
    parameter int         OPEN_CYC    = 500,
    parameter int         LOCKOUT_CYC = 1000,
    parameter logic [7:0] RESET_CODE  = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic       key_bit,
    input  logic       key_clear,
    input  logic       prog_req,
    input  logic       det_match,
    output logic       det_x,
    output logic       det_rst_n,
    output logic [1:8] code,
    output logic       unlock,
    output logic       busy,
    output logic       locked_out,
    output logic [2:0] fail_cnt,
    output logic       alarm
);

    localparam int T_A   = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
    localparam int T_B   = (MATCH_WAIT > CODE_LEN) ? MATCH_WAIT : CODE_LEN;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int TW    = $clog2(T_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REPLAY,
        S_WAIT,
        S_OPEN,
        S_PROGRAM,
        S_LOCKOUT
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_cnt, cnt_next;
    logic [7:0]    entry, entry_next;
    logic [7:0]    code_reg, code_next;
    logic [2:0]    fail_reg, fail_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            entry    <= '0;
            code_reg <= RESET_CODE;
            fail_reg <= '0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            bit_cnt  <= cnt_next;
            entry    <= entry_next;
            code_reg <= code_next;
            fail_reg <= fail_next;
        end
    end

    // The detector runs every clock, so it is held in reset except while an attempt is replayed and judged.
    always_comb begin
        state_next = state;
        timer_next = timer;
        cnt_next   = bit_cnt;
        entry_next = entry;
        code_next  = code_reg;
        fail_next  = fail_reg;
        det_x      = 1'b0;
        det_rst_n  = 1'b0;
        unlock     = 1'b0;
        busy       = 1'b0;
        locked_out = 1'b0;
        case (state)
            S_IDLE, S_PROGRAM: begin
                if (key_clear) begin
                    cnt_next = '0;
                    if (state == S_PROGRAM) state_next = S_IDLE;
                end else if (key_valid) begin
                    entry_next = {entry[6:0], key_bit};
                    if (bit_cnt == 3'(CODE_LEN - 1)) begin
                        cnt_next   = '0;
                        timer_next = '0;
                        if (state == S_IDLE) begin
                            state_next = S_REPLAY;
                        end else begin
                            code_next  = entry_next;
                            state_next = S_IDLE;
                        end
                    end else begin
                        cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            S_REPLAY: begin
                det_rst_n = 1'b1;
                busy      = 1'b1;
                det_x     = entry[~timer[2:0]];
                if (timer == TW'(CODE_LEN - 1)) begin
                    timer_next = '0;
                    state_next = S_WAIT;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            S_WAIT: begin
                det_rst_n = 1'b1;
                busy      = 1'b1;
                if (det_match) begin
                    fail_next  = '0;
                    timer_next = '0;
                    state_next = S_OPEN;
                end else if (timer == TW'(MATCH_WAIT - 1)) begin
                    timer_next = '0;
                    if (fail_reg >= 3'(MAX_TRIES - 1)) begin
                        fail_next  = 3'(MAX_TRIES);
                        state_next = S_LOCKOUT;
                    end else begin
                        fail_next  = fail_reg + 3'd1;
                        state_next = S_IDLE;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            S_OPEN: begin
                unlock = 1'b1;
                if (prog_req) begin
                    cnt_next   = '0;
                    timer_next = '0;
                    state_next = S_PROGRAM;
                end else if (timer == TW'(OPEN_CYC - 1)) begin
                    timer_next = '0;
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            S_LOCKOUT: begin
                locked_out = 1'b1;
                if (timer == TW'(LOCKOUT_CYC - 1)) begin
                    timer_next = '0;
                    fail_next  = '0;
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = '0;
                cnt_next   = '0;
            end
        endcase
    end

    assign code     = code_reg;
    assign fail_cnt = fail_reg;

`ifdef LOCK_ALARM_EN
    assign alarm = (state == S_LOCKOUT) && (timer == '0);
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: table of attempts plus hand sequences for
// programming, partial-entry clear, held strobes and mid-operation reset.
module tb_lock_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_bit = 1'b0;
    logic       key_clear = 1'b0;
    logic       prog_req = 1'b0;
    logic       det_match = 1'b0;
    logic       det_x, det_rst_n, unlock, busy, locked_out, alarm;
    logic [1:8] code;
    logic [2:0] fail_cnt;

    int         tests = 0;
    int         failed = 0;
    logic [7:0] model_code = 8'hA5;

    typedef struct {
        logic [7:0] bits;
        logic       exp_unlock;
        logic [2:0] exp_fail;
        logic       exp_lock;
    } vec_t;
    vec_t vecs[5];

    lock_sequencer dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_bit(key_bit),
        .key_clear(key_clear), .prog_req(prog_req), .det_match(det_match),
        .det_x(det_x), .det_rst_n(det_rst_n), .code(code), .unlock(unlock),
        .busy(busy), .locked_out(locked_out), .fail_cnt(fail_cnt), .alarm(alarm)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] bits, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            key_valid = 1'b1;
            key_bit   = bits[i];
            tick();
            key_valid = 1'b0;
        end
    endtask

    // Keys a full attempt, checks the replay burst, and plays the detector's match response.
    task automatic do_attempt(input logic [7:0] bits, input logic hold);
        logic match;
        match = (bits == model_code);
        apply_stimulus(bits, 8);
        key_valid = hold;
        key_bit   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                check_output("replay_busy", busy, 1);
                check_output("replay_det_rst_n", det_rst_n, 1);
            end
            check_output($sformatf("replay_det_x[%0d]", i), det_x, bits[7-i]);
            tick();
        end
        for (int w = 0; w < 4; w++) begin
            check_output("wait_busy", busy, 1);
            if (w == 0) check_output("wait_det_x", det_x, 0);
            det_match = match && (w == 1);
            if (det_match || w == 3) key_valid = 1'b0;
            tick();
            if (det_match) begin
                det_match = 1'b0;
                break;
            end
        end
        key_valid = 1'b0;
        check_output("post_wait_busy", busy, 0);
    endtask

    task automatic wait_open();
        int n = 0;
        while (unlock === 1'b1 && n < 600) begin
            n++;
            tick();
        end
        check_output("open_cycles", n, 500);
    endtask

    task automatic run_lockout();
        int n = 0;
        int a = 0;
        int exp_alarm;
`ifdef LOCK_ALARM_EN
        exp_alarm = 1;
`else
        exp_alarm = 0;
`endif
        while (locked_out === 1'b1 && n < 1100) begin
            if (alarm === 1'b1) a++;
            key_valid = 1'b1;
            key_bit   = 1'($urandom);
            n++;
            tick();
        end
        key_valid = 1'b0;
        check_output("lockout_cycles", n, 1000);
        check_output("alarm_pulses", a, exp_alarm);
        check_output("fail_after_lockout", fail_cnt, 0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 3'd0, 1'b0};
        vecs[1] = '{8'hF0, 1'b0, 3'd1, 1'b0};
        vecs[2] = '{8'hF0, 1'b0, 3'd2, 1'b0};
        vecs[3] = '{8'hF0, 1'b0, 3'd3, 1'b1};
        vecs[4] = '{8'hA5, 1'b1, 3'd0, 1'b0};

        tick();
        tick();
        check_output("rst_det_rst_n", det_rst_n, 0);
        check_output("rst_det_x", det_x, 0);
        check_output("rst_unlock", unlock, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_locked_out", locked_out, 0);
        check_output("rst_fail_cnt", fail_cnt, 0);
        check_output("rst_alarm", alarm, 0);
        check_output("rst_code", code, 8'hA5);
        reset = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            do_attempt(vecs[v].bits, 1'b0);
            check_output($sformatf("vec%0d_unlock", v), unlock, vecs[v].exp_unlock);
            check_output($sformatf("vec%0d_fail", v), fail_cnt, vecs[v].exp_fail);
            check_output($sformatf("vec%0d_lock", v), locked_out, vecs[v].exp_lock);
            if (vecs[v].exp_unlock) wait_open();
            if (vecs[v].exp_lock) run_lockout();
        end

        // Reprogram to 3C while open.
        do_attempt(8'hA5, 1'b0);
        check_output("prog_open", unlock, 1);
        prog_req = 1'b1;
        tick();
        prog_req = 1'b0;
        check_output("prog_unlock_drop", unlock, 0);
        apply_stimulus(8'h3C, 7);
        check_output("prog_code_partial", code, 8'hA5);
        key_valid = 1'b1;
        key_bit   = 1'b0;
        tick();
        key_valid = 1'b0;
        check_output("prog_code_loaded", code, 8'h3C);
        model_code = 8'h3C;

        // New code opens; aborted reprogram leaves it intact; old code fails.
        do_attempt(8'h3C, 1'b0);
        check_output("new_code_unlock", unlock, 1);
        prog_req = 1'b1;
        tick();
        prog_req = 1'b0;
        apply_stimulus(8'hFF, 3);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check_output("abort_code", code, 8'h3C);
        check_output("abort_unlock", unlock, 0);
        do_attempt(8'hA5, 1'b0);
        check_output("old_code_unlock", unlock, 0);
        check_output("old_code_fail", fail_cnt, 1);

        // Partial entry, then clear together with a strobe: both partial bits and strobe dropped.
        apply_stimulus(8'b10110000, 5);
        key_valid = 1'b1;
        key_clear = 1'b1;
        key_bit   = 1'b1;
        tick();
        key_valid = 1'b0;
        key_clear = 1'b0;
        do_attempt(8'h3C, 1'b0);
        check_output("clear_unlock", unlock, 1);
        check_output("clear_fail", fail_cnt, 0);
        wait_open();

        // key_valid held through replay and wait must not disturb the entry count.
        do_attempt(8'hF0, 1'b1);
        check_output("hold_unlock", unlock, 0);
        check_output("hold_fail", fail_cnt, 1);
        do_attempt(8'h3C, 1'b0);
        check_output("hold_next_unlock", unlock, 1);
        check_output("hold_next_fail", fail_cnt, 0);
        wait_open();

        // Reset mid-REPLAY drops the programmed code.
        apply_stimulus(8'h3C, 8);
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_output("mid_replay_busy", busy, 0);
        check_output("mid_replay_det_rst_n", det_rst_n, 0);
        check_output("mid_replay_det_x", det_x, 0);
        check_output("mid_replay_code", code, 8'hA5);
        tick();
        reset = 1'b1;
        model_code = 8'hA5;
        tick();

        // Reset mid-OPEN.
        do_attempt(8'hA5, 1'b0);
        check_output("pre_reset_open", unlock, 1);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b0;
        #1;
        check_output("mid_open_unlock", unlock, 0);
        check_output("mid_open_code", code, 8'hA5);
        check_output("mid_open_fail", fail_cnt, 0);
        check_output("mid_open_det_rst_n", det_rst_n, 0);
        tick();
        reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
